// File: rtl/pipe_pkg.sv
// Shared types for the elastic pipeline stage register.
package pipe_pkg;

  localparam int unsigned PIPE_DATA_W = 160;
  localparam int unsigned PIPE_CTRL_W = 32;
  localparam int unsigned PIPE_RD_W   = 5;
  localparam int unsigned PIPE_CNT_W  = 16;

  // Occupancy-encoded FSM states: the encoding doubles as the held-entry count.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } pipe_state_t;

  // One held entry: opaque payload, control word and writeback destination.
  typedef struct packed {
    logic [PIPE_DATA_W-1:0] data;
    logic [PIPE_CTRL_W-1:0] ctrl;
    logic [PIPE_RD_W-1:0]   rd;
    logic                   we;
  } pipe_slot_t;

endpackage

// File: rtl/pipe_slot.sv
// Load/clear register holding one pipeline entry.
module pipe_slot
  import pipe_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       clr,
  input  pipe_slot_t d,
  output pipe_slot_t q
);

  // Reset wipes every field; clear kills only the side-effecting fields so the
  // payload stays observable while the slot is empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (clr) begin
      q.ctrl <= '0;
      q.we   <= 1'b0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/pipe_stage_buf.sv
// Elastic stage register with a 2-entry skid buffer, flush, occupancy,
// saturating stall counter and writeback-forwarding outputs.
module pipe_stage_buf
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W = PIPE_DATA_W,
  parameter int unsigned CTRL_W = PIPE_CTRL_W,
  parameter int unsigned CNT_W  = PIPE_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [4:0]        in_rd,
  input  logic              in_we,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [4:0]        fwd_rd,
  output logic              fwd_we,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  pipe_state_t state;
  pipe_state_t next_state;

  pipe_slot_t in_slot;
  pipe_slot_t main_d;
  pipe_slot_t main_q;
  pipe_slot_t skid_q;

  logic main_load;
  logic skid_load;
  logic main_from_skid;
  logic in_fire;
  logic out_fire;

  // Handshake decode; in_ready depends on registered state only.
  always_comb begin
    in_ready  = (state != TWO);
    out_valid = (state != EMPTY);
    in_fire   = in_valid & in_ready;
    out_fire  = out_valid & out_ready;
  end

  // Pack the incoming entry.
  always_comb begin
    in_slot      = '0;
    in_slot.data = in_data;
    in_slot.ctrl = in_ctrl;
    in_slot.rd   = in_rd;
    in_slot.we   = in_we;
  end

  // Next-state and slot-load decisions; flush overrides every handshake.
  always_comb begin
    next_state     = state;
    main_load      = 1'b0;
    skid_load      = 1'b0;
    main_from_skid = 1'b0;
    case (state)
      EMPTY: begin
        if (in_fire) begin
          main_load  = 1'b1;
          next_state = ONE;
        end
      end
      ONE: begin
        if (in_fire && out_fire) begin
          main_load = 1'b1;
        end else if (in_fire) begin
          skid_load  = 1'b1;
          next_state = TWO;
        end else if (out_fire) begin
          next_state = EMPTY;
        end
      end
      TWO: begin
        if (out_fire) begin
          main_load      = 1'b1;
          main_from_skid = 1'b1;
          next_state     = ONE;
        end
      end
      default: next_state = EMPTY;
    endcase
    if (flush) begin
      next_state = EMPTY;
      main_load  = 1'b0;
      skid_load  = 1'b0;
    end
  end

  // Main slot is refilled either from the input or by promoting the skid entry.
  always_comb begin
    main_d = main_from_skid ? skid_q : in_slot;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= EMPTY;
    end else begin
      state <= next_state;
    end
  end

  // Saturating count of cycles where the head is blocked; flush leaves it alone.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready && (stall_cnt != CNT_MAX)) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

  pipe_slot u_main (
    .clk  (clk),
    .rst  (rst),
    .load (main_load),
    .clr  (flush),
    .d    (main_d),
    .q    (main_q)
  );

  pipe_slot u_skid (
    .clk  (clk),
    .rst  (rst),
    .load (skid_load),
    .clr  (flush),
    .d    (in_slot),
    .q    (skid_q)
  );

  // Head presentation; forwarding write-enable is gated by a valid head.
  always_comb begin
    out_data  = main_q.data;
    out_ctrl  = main_q.ctrl;
    fwd_rd    = main_q.rd;
    fwd_we    = out_valid & main_q.we;
    occupancy = 2'(state);
  end

endmodule
